// File: rtl/led_zone_shifter_if.sv
// FIFO read port and LED driver link of the zone shifter.
// master = zone shifter, slave = FIFO / LED driver side.
interface led_zone_shifter_if #(
   parameter int DATA_WIDTH = 24
);
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_empty;
   logic                  led_sclk;
   logic                  led_sdo;
   logic                  led_latch;

   modport master (
      output rd_en,
      input  rd_data,
      input  rd_empty,
      output led_sclk,
      output led_sdo,
      output led_latch
   );

   modport slave (
      input  rd_en,
      output rd_data,
      output rd_empty,
      input  led_sclk,
      input  led_sdo,
      input  led_latch
   );
endinterface

// File: rtl/led_zone_shifter.sv
// Pops one FIFO word per zone, shifts it MSB-first on led_sclk/led_sdo and latches the frame.
// Optional frame checksum byte enabled by defining LED_CHECKSUM_EN.
module led_zone_shifter #(
   parameter int DATA_WIDTH        = 24,
   parameter int ZONE_NUM          = 64,
   parameter int CLK_DIV           = 4,
   parameter int LATCH_CYCLES      = 8,
   parameter int UNDERFLOW_TIMEOUT = 1024
) (
   input  logic               rd_clk,
   input  logic               rd_rst,
   input  logic               frame_start,
   led_zone_shifter_if.master lz,
   output logic               busy,
   output logic               frame_done,
   output logic               underflow
);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam int WAIT_W = $clog2(UNDERFLOW_TIMEOUT + 1);
   localparam int LAT_W  = $clog2(LATCH_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_POP, S_LOAD, S_SHIFT,
`ifdef LED_CHECKSUM_EN
      S_CSUM,
`endif
      S_LATCH
   } state_t;

   state_t                state_q, state_d;
   logic [11:0]           zone_cnt_q, zone_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]            div_cnt_q, div_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic                  sclk_q, sclk_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  underflow_q, underflow_d;
   logic                  done_q, done_d;
   logic [11:0]           zone_inc;
   logic                  shifting, half_end, bit_end;

`ifdef LED_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   function automatic logic [7:0] byte_sum(input logic [DATA_WIDTH-1:0] w);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < DATA_WIDTH / 8; i++) s = s + w[i*8 +: 8];
      return s;
   endfunction

   assign shifting = (state_q == S_SHIFT) || (state_q == S_CSUM);
`else
   assign shifting = (state_q == S_SHIFT);
`endif

   assign half_end = (div_cnt_q == 8'(CLK_DIV - 1));
   assign bit_end  = half_end && sclk_q;
   assign zone_inc = zone_cnt_q + 12'd1;

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= S_IDLE;
         zone_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         lat_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         underflow_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         zone_cnt_q  <= zone_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         sclk_q      <= sclk_d;
         underflow_q <= underflow_d;
         done_q      <= done_d;
      end
      shift_q <= shift_d;
`ifdef LED_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
   end

   always_comb begin
      state_d     = state_q;
      zone_cnt_d  = zone_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      sclk_d      = sclk_q;
      shift_d     = shift_q;
      underflow_d = underflow_q;
      done_d      = 1'b0;
`ifdef LED_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      // Common bit timer: toggle sclk every CLK_DIV cycles, advance the bit after the high half.
      if (shifting) begin
         if (half_end) begin
            div_cnt_d = '0;
            sclk_d    = !sclk_q;
         end else begin
            div_cnt_d = div_cnt_q + 8'd1;
         end
         if (bit_end) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d     = S_WAIT;
               zone_cnt_d  = '0;
               wait_cnt_d  = '0;
               underflow_d = 1'b0;
`ifdef LED_CHECKSUM_EN
               csum_d      = '0;
`endif
            end
         end
         S_WAIT: begin
            if (!lz.rd_empty) begin
               state_d = S_POP;
            end else if (wait_cnt_q == WAIT_W'(UNDERFLOW_TIMEOUT - 1)) begin
               state_d     = S_IDLE;
               underflow_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_POP: state_d = S_LOAD;
         S_LOAD: begin
            state_d   = S_SHIFT;
            shift_d   = lz.rd_data;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
`ifdef LED_CHECKSUM_EN
            csum_d    = csum_q + byte_sum(lz.rd_data);
`endif
         end
         S_SHIFT: begin
            if (bit_end && bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
               zone_cnt_d = zone_inc;
               wait_cnt_d = '0;
               lat_cnt_d  = '0;
               if (zone_inc == 12'(ZONE_NUM)) begin
`ifdef LED_CHECKSUM_EN
                  state_d   = S_CSUM;
                  shift_d   = {csum_q, {(DATA_WIDTH - 8){1'b0}}};
                  bit_cnt_d = '0;
`else
                  state_d   = S_LATCH;
`endif
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
`ifdef LED_CHECKSUM_EN
         S_CSUM: begin
            if (bit_end && bit_cnt_q == BIT_W'(7)) begin
               state_d   = S_LATCH;
               lat_cnt_d = '0;
            end
         end
`endif
         S_LATCH: begin
            if (lat_cnt_q == LAT_W'(LATCH_CYCLES - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lz.rd_en     = (state_q == S_POP) && !rd_rst;
      lz.led_sclk  = shifting && sclk_q;
      lz.led_sdo   = shifting && shift_q[DATA_WIDTH-1];
      lz.led_latch = (state_q == S_LATCH);
      busy         = (state_q != S_IDLE);
      frame_done   = done_q;
      underflow    = underflow_q;
   end
endmodule
